// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product, signed/unsigned at runtime.
// Optional `SEQ_MULT_EARLY_TERM_EN leaves CALC as soon as the remaining multiplier bits are all zero.
module seq_mult #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      a_reg, a_nxt;
  logic [WIDTH-1:0]   b_reg, b_nxt;
  logic [PW-1:0]      acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               neg, neg_nxt;
  logic               busy_nxt, done_nxt;
  logic [PW-1:0]      product_nxt;
  logic [WIDTH-1:0]   b_shift;
  logic [PW-1:0]      acc_sum;

  // Unsigned magnitude of an operand; the most negative value maps to 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    if (is_signed && sv < 0)
      return ~v + WIDTH'(1);
    else
      return v;
  endfunction

  // Re-applies the sign recorded at start to the accumulated magnitude product.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic n);
    return n ? (~v + PW'(1)) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      a_reg   <= a_nxt;
      b_reg   <= b_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      neg     <= neg_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      product <= product_nxt;
    end
  end

  assign b_shift = b_reg >> 1;
  assign acc_sum = acc + a_reg;

  always_comb begin
    state_nxt   = state;
    a_nxt       = a_reg;
    b_nxt       = b_reg;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    neg_nxt     = neg;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    product_nxt = product;
    case (state)
      IDLE: begin
        if (start) begin
          a_nxt     = PW'(magnitude(a_in, signed_mode));
          b_nxt     = magnitude(b_in, signed_mode);
          acc_nxt   = '0;
          cnt_nxt   = CNT_W'(WIDTH);
          neg_nxt   = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          busy_nxt  = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (b_reg[0])
          acc_nxt = acc_sum;
        a_nxt   = a_reg << 1;
        b_nxt   = b_shift;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1))
          state_nxt = FIX;
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (b_shift == '0)
          state_nxt = FIX;
`else
`endif
      end
      FIX: begin
        product_nxt = apply_sign(acc, neg);
        done_nxt    = 1'b1;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised sequential shift-and-add multiplier with an integrated controller.
- Successor to the fixed 16-bit repeated-addition multiplier datapath and its external controller.
- Adds generic WIDTH, runtime signed/unsigned mode, a start/busy/done handshake and a bounded latency of WIDTH+1 cycles.
- Sits as an arithmetic coprocessor beside the main datapath; operands come from registers and the product is held until the next operation.

Parameters:
- WIDTH, 16, operand width in bits (≥2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a_in  input  WIDTH  multiplicand; sampled with start.
- b_in  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product is valid.
- product  output  2*WIDTH  result; held stable until the next result is written.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, product=0; internal acc/a/b/cnt/neg cleared. Deassertion takes effect at the next clk edge. Reset mid-operation aborts with no done pulse and product=0.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - done is cleared on the edge after its pulse.
  - If start=1 on an edge: load a_reg (2*WIDTH, zero-extended magnitude of a_in), b_reg (WIDTH, magnitude of b_in), acc=0, cnt=WIDTH.
  - Set neg = signed_mode & (a_in[MSB] ^ b_in[MSB]); set busy=1; go to CALC.
  - Magnitude = two's-complement negation when signed_mode and MSB=1, else the raw value. -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned WIDTH bits.
- CALC, each edge:
  - If b_reg[0]: acc = acc + a_reg (mod 2^(2*WIDTH); it cannot overflow).
  - a_reg <<= 1; b_reg >>= 1; cnt -= 1.
  - When cnt reaches 0 on this edge, go to FIX.
  - Always exactly WIDTH CALC edges unless the optional feature is enabled.
- FIX, one edge:
  - product = neg ? -acc : acc (2*WIDTH two's complement).
  - done=1, busy=0; go to IDLE.
- Latency: start sampled at edge 0; product/done/busy update at edge WIDTH+1. done is high for exactly one cycle.
- start while busy=1 is ignored; no queuing, and operands are not re-sampled.
- start in the cycle done=1 (state IDLE) is accepted: busy rises on that edge and done falls on the same edge.
- a_in, b_in and signed_mode may change freely after the start edge.
- Unsigned mode: the full 2*WIDTH unsigned product. Signed mode: the exact 2*WIDTH signed product; the extreme case (-2^(W-1))^2 = 2^(2W-2) is representable.
- Zero operands follow the normal path; no special-case shortcut unless the feature is enabled.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: CALC also exits to FIX on the edge where the updated b_reg equals 0.
  - Latency = max(1, position of the highest set bit of |b|, +1) CALC edges, + 1 FIX edge.
  - With b=0, there is still exactly 1 CALC edge.
  - Results are identical to the non-feature build.
- Undefined: fixed WIDTH+1 latency; the b_reg==0 comparator is absent.

Test Plan (WIDTH=16):
- Unsigned: a=0xFFFF, b=0xFFFF, signed_mode=0, start pulse -> done exactly 17 edges later; product=0xFFFE0001; busy high for 17 cycles.
- Signed: a=0xFFFD (-3), b=0x0005 -> product=0xFFFFFFF1. Then a=0x8000, b=0x8000 -> 0x40000000. Then a=0x8000, b=0x0001 -> 0xFFFF8000.
- Handshake: start held high continuously with a=3, b=5 -> back-to-back results 15, one every 18 cycles (done edge plus re-accept on the same cycle); a_in changed mid-operation has no effect on the result.
- Ignored start: pulse start with a=2, b=2 while busy on an operation with a=7, b=9 -> single done, product=63.
- Reset mid-op: rst_n low asynchronously at CALC cycle 5 -> busy=0, done=0, product=0 immediately; no done after release; the next op a=4, b=4 gives 16.
- SEQ_MULT_EARLY_TERM_EN defined: a=7, b=1 -> done 2 edges after start, product=7. a=5, b=0 -> done 2 edges after start, product=0. a=1, b=0x8000 unsigned -> 17 edges, product=0x8000.
